// File: rtl/sock_line_fsm.sv
// Multi-line sock production controller: NUM_LINES lines of LOAD/KNIT/DYE/PACK sharing one dye vat.
// Latency: start to done_o is 10 cycles with defaults, no vat contention, temp_ok and box_ok high.
// Backpressure: lines wait in DYE_WAIT for the vat, DYE freezes while temp_ok is low, PACK waits for box_ok.
module sock_line_fsm #(
  parameter int NUM_LINES = 2,
  parameter int MAT_W     = 3,
  parameter int CNT_W     = 3,
  parameter int KNIT_CYC  = 4,
  parameter int DYE_CYC   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LINES-1:0]         start,
  input  logic [NUM_LINES*MAT_W-1:0]   mat,
  input  logic [NUM_LINES-1:0]         stock_ok,
  input  logic                         temp_ok,
  input  logic [NUM_LINES-1:0]         box_ok,
  input  logic [NUM_LINES-1:0]         ack_fault,
  output logic [NUM_LINES*3-1:0]       state_o,
  output logic [NUM_LINES*MAT_W-1:0]   mat_o,
  output logic [NUM_LINES*CNT_W-1:0]   count_o,
  output logic [NUM_LINES-1:0]         done_o,
  output logic [NUM_LINES-1:0]         wrap_o,
  output logic [NUM_LINES-1:0]         fault_o,
  output logic                         vat_busy
);

  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_LOAD     = 3'b001;
  localparam logic [2:0] S_KNIT     = 3'b010;
  localparam logic [2:0] S_DYE_WAIT = 3'b011;
  localparam logic [2:0] S_DYE      = 3'b100;
  localparam logic [2:0] S_PACK     = 3'b101;
  localparam logic [2:0] S_FAULT    = 3'b110;

  localparam int TMAX = (KNIT_CYC > DYE_CYC) ? KNIT_CYC : DYE_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  localparam logic [TW-1:0]    KNIT_LOAD = TW'(KNIT_CYC - 1);
  localparam logic [TW-1:0]    DYE_LOAD  = TW'(DYE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [NUM_LINES-1:0][2:0]       state_q, state_d;
  logic [NUM_LINES-1:0][TW-1:0]    timer_q, timer_d;
  logic [NUM_LINES-1:0][MAT_W-1:0] mat_q,   mat_d;
  logic [NUM_LINES-1:0][CNT_W-1:0] cnt_q,   cnt_d;
  logic [NUM_LINES-1:0]            done_q,  done_d;
  logic [NUM_LINES-1:0]            wrap_q,  wrap_d;
  logic [PW-1:0]                   ptr_q,   ptr_d;
  logic [NUM_LINES-1:0]            grant;
  logic                            vat_held;
  logic                            found;
  logic [PW-1:0]                   idx;

  // Vat arbiter: the vat counts as free when nobody stays in DYE past this edge,
  // so a waiter can be granted on the same cycle the current dyer moves to PACK.
  always_comb begin
    vat_held = 1'b0;
    found    = 1'b0;
    grant    = '0;
    ptr_d    = ptr_q;
    idx      = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (state_q[i] == S_DYE && !(timer_q[i] == '0 && temp_ok)) vat_held = 1'b1;
    end
    if (!vat_held && temp_ok) begin
      for (int k = 0; k < NUM_LINES; k++) begin
        idx = PW'((int'(ptr_q) + k) % NUM_LINES);
        if (!found && state_q[idx] == S_DYE_WAIT) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
          ptr_d      = PW'((int'(idx) + 1) % NUM_LINES);
        end
      end
    end
  end

  // Per-line next-state, timer, material latch and packed-pair counter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mat_d   = mat_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    wrap_d  = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      case (state_q[i])
        S_IDLE: begin
          if (start[i]) begin
            if (!$onehot(mat[i*MAT_W +: MAT_W])) begin
              state_d[i] = S_FAULT;
              mat_d[i]   = '0;
            end else if (stock_ok[i]) begin
              state_d[i] = S_LOAD;
              mat_d[i]   = mat[i*MAT_W +: MAT_W];
            end
          end
        end
        S_LOAD: begin
          state_d[i] = S_KNIT;
          timer_d[i] = KNIT_LOAD;
        end
        S_KNIT: begin
          // Losing stock outranks the timer expiring on the same cycle.
          if (!stock_ok[i]) begin
            state_d[i] = S_FAULT;
            mat_d[i]   = '0;
          end else if (timer_q[i] == '0) begin
            state_d[i] = S_DYE_WAIT;
          end else begin
            timer_d[i] = timer_q[i] - 1'b1;
          end
        end
        S_DYE_WAIT: begin
          if (grant[i]) begin
            state_d[i] = S_DYE;
            timer_d[i] = DYE_LOAD;
          end
        end
        S_DYE: begin
          // A cold vat simply pauses dyeing; the exit cycle itself must be a warm one.
          if (temp_ok) begin
            if (timer_q[i] == '0) state_d[i] = S_PACK;
            else                  timer_d[i] = timer_q[i] - 1'b1;
          end
        end
        S_PACK: begin
          if (box_ok[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = cnt_q[i] + 1'b1;
            done_d[i]  = 1'b1;
            wrap_d[i]  = (cnt_q[i] == CNT_MAX);
          end
        end
        S_FAULT: begin
          mat_d[i] = '0;
          if (ack_fault[i]) state_d[i] = S_IDLE;
        end
        default: begin
          state_d[i] = S_IDLE;
        end
      endcase
    end
  end

  // State registers; reset also frees the vat since no line can remain in DYE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      timer_q <= '0;
      mat_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      wrap_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      mat_q   <= mat_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output decode: fault and vat status follow the registered state directly.
  always_comb begin
    vat_busy = 1'b0;
    fault_o  = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      fault_o[i] = (state_q[i] == S_FAULT);
      if (state_q[i] == S_DYE) vat_busy = 1'b1;
    end
  end

  assign state_o = state_q;
  assign mat_o   = mat_q;
  assign count_o = cnt_q;
  assign done_o  = done_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_sock_line_fsm.sv
// Testbench for sock_line_fsm: directed scenarios plus randomized traffic against a behavioural model.
// Model tracks each line as a stage plus remaining work cycles; vat is granted only if nobody dyes next cycle.
// Every comparison goes through check(); one summary line at the end.
module tb_sock_line_fsm;
  localparam int N  = 2;
  localparam int MW = 3;
  localparam int CW = 3;
  localparam int KC = 4;
  localparam int DC = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    start, stock_ok, box_ok, ack_fault;
  logic [N*MW-1:0] mat;
  logic            temp_ok;
  logic [N*3-1:0]  state_o;
  logic [N*MW-1:0] mat_o;
  logic [N*CW-1:0] count_o;
  logic [N-1:0]    done_o, wrap_o, fault_o;
  logic            vat_busy;

  sock_line_fsm #(.NUM_LINES(N), .MAT_W(MW), .CNT_W(CW), .KNIT_CYC(KC), .DYE_CYC(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mat(mat), .stock_ok(stock_ok),
    .temp_ok(temp_ok), .box_ok(box_ok), .ack_fault(ack_fault), .state_o(state_o),
    .mat_o(mat_o), .count_o(count_o), .done_o(done_o), .wrap_o(wrap_o),
    .fault_o(fault_o), .vat_busy(vat_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model, stage numbers: 0 idle,1 load,2 knit,3 wait vat,4 dye,5 pack,6 fault.
  int m_st[N], m_left[N], m_mat[N], m_cnt[N];
  bit m_done[N], m_wrap[N];
  int m_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_left[i] = 0; m_mat[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_wrap[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic model_step();
    int nst[N], nleft[N], nmat[N], ncnt[N];
    bit busy, g;
    logic [MW-1:0] mv;
    int idx;
    busy = 0; g = 0;
    for (int i = 0; i < N; i++) begin
      nst[i] = m_st[i]; nleft[i] = m_left[i]; nmat[i] = m_mat[i]; ncnt[i] = m_cnt[i];
      m_done[i] = 0; m_wrap[i] = 0;
      mv = mat[i*MW +: MW];
      case (m_st[i])
        0: if (start[i]) begin
             if ($countones(mv) != 1) begin nst[i] = 6; nmat[i] = 0; end
             else if (stock_ok[i]) begin nst[i] = 1; nmat[i] = int'(mv); end
           end
        1: begin nst[i] = 2; nleft[i] = KC; end
        2: if (!stock_ok[i]) begin nst[i] = 6; nmat[i] = 0; end
           else begin nleft[i] = m_left[i] - 1; if (nleft[i] == 0) nst[i] = 3; end
        4: if (temp_ok) begin nleft[i] = m_left[i] - 1; if (nleft[i] == 0) nst[i] = 5; end
        5: if (box_ok[i]) begin
             nst[i] = 0; ncnt[i] = (m_cnt[i] + 1) % (1 << CW);
             m_done[i] = 1; m_wrap[i] = (ncnt[i] == 0);
           end
        6: begin nmat[i] = 0; if (ack_fault[i]) nst[i] = 0; end
        default: ;
      endcase
    end
    for (int i = 0; i < N; i++) if (nst[i] == 4) busy = 1;
    if (!busy && temp_ok) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!g && m_st[idx] == 3) begin
          nst[idx] = 4; nleft[idx] = DC; m_ptr = (idx + 1) % N; g = 1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      m_st[i] = nst[i]; m_left[i] = nleft[i]; m_mat[i] = nmat[i]; m_cnt[i] = ncnt[i];
    end
  endtask

  task automatic compare();
    int ndye;
    bit vb;
    ndye = 0; vb = 0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("state%0d", i), 32'(state_o[i*3 +: 3]), 32'(m_st[i]));
      check($sformatf("count%0d", i), 32'(count_o[i*CW +: CW]), 32'(m_cnt[i]));
      check($sformatf("mat%0d", i), 32'(mat_o[i*MW +: MW]), 32'(m_mat[i]));
      check($sformatf("done%0d", i), 32'(done_o[i]), 32'(m_done[i]));
      check($sformatf("wrap%0d", i), 32'(wrap_o[i]), 32'(m_wrap[i]));
      check($sformatf("fault%0d", i), 32'(fault_o[i]), 32'(m_st[i] == 6));
      if (state_o[i*3 +: 3] == 3'd4) ndye++;
      if (m_st[i] == 4) vb = 1;
    end
    check("vat_busy", 32'(vat_busy), 32'(vb));
    check("vat_excl", 32'(ndye <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
    compare();
  endtask

  task automatic set_idle();
    start = '0; mat = {N{3'b001}}; stock_ok = '1; temp_ok = 1'b1; box_ok = '1; ack_fault = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic wait_done(input int line, input int bound, output int cyc);
    cyc = -1;
    for (int t = 1; t <= bound; t++) begin
      tick();
      if (done_o[line]) begin cyc = t; break; end
    end
  endtask

  int seq1[10] = '{1, 2, 2, 2, 2, 3, 4, 4, 5, 0};
  int c;

  initial begin
    reset = 1'b1;
    set_idle();
    model_reset();
    do_reset();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_vat", 32'(vat_busy), 32'd0);

    // Single job on line 0: exact state trace and done timing.
    start[0] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      start[0] = 1'b0;
      check($sformatf("seq1_t%0d", t + 1), 32'(state_o[2:0]), 32'(seq1[t]));
      check($sformatf("seq1_done_t%0d", t + 1), 32'(done_o[0]), 32'(t == 9));
    end
    check("seq1_count", 32'(count_o[2:0]), 32'd1);

    // Non-one-hot material faults even with no stock; count survives the fault.
    start[0] = 1'b1; mat[2:0] = 3'b011; stock_ok[0] = 1'b0;
    tick();
    check("badmat_state", 32'(state_o[2:0]), 32'd6);
    check("badmat_fault", 32'(fault_o[0]), 32'd1);
    check("badmat_mat", 32'(mat_o[2:0]), 32'd0);
    set_idle(); ack_fault[0] = 1'b1;
    tick();
    ack_fault[0] = 1'b0;
    check("ack_state", 32'(state_o[2:0]), 32'd0);
    check("ack_count", 32'(count_o[2:0]), 32'd1);

    // Stock loss during KNIT on line 1.
    start[1] = 1'b1; mat[5:3] = 3'b010;
    tick(); start[1] = 1'b0;
    tick();
    check("knit_state", 32'(state_o[5:3]), 32'd2);
    check("knit_mat", 32'(mat_o[5:3]), 32'd2);
    stock_ok[1] = 1'b0;
    tick();
    check("stockloss_state", 32'(state_o[5:3]), 32'd6);
    stock_ok[1] = 1'b1; ack_fault[1] = 1'b1;
    tick();
    ack_fault[1] = 1'b0;
    check("stockloss_ack", 32'(state_o[5:3]), 32'd0);

    // Both lines start together: vat contention.
    do_reset();
    start = 2'b11;
    for (int t = 1; t <= 12; t++) begin
      tick();
      start = '0;
      if (t == 7 || t == 8) check($sformatf("cont_l0dye_t%0d", t), 32'(state_o[2:0]), 32'd4);
      if (t == 8) check("cont_l1wait", 32'(state_o[5:3]), 32'd3);
      if (t == 9 || t == 10) check($sformatf("cont_l1dye_t%0d", t), 32'(state_o[5:3]), 32'd4);
      if (t == 10) check("cont_l0done", 32'(done_o[0]), 32'd1);
      if (t == 12) check("cont_l1done", 32'(done_o[1]), 32'd1);
    end

    // Reset while line 0 dyes.
    start = 2'b11;
    for (int t = 1; t <= 7; t++) begin tick(); start = '0; end
    check("middye_busy", 32'(vat_busy), 32'd1);
    do_reset();
    check("middye_state", 32'(state_o), 32'd0);
    check("middye_count", 32'(count_o), 32'd0);
    check("middye_vat", 32'(vat_busy), 32'd0);

    // Cold vat for 3 cycles in DYE delays done by exactly 3.
    start[0] = 1'b1;
    for (int t = 1; t <= 7; t++) begin tick(); start[0] = 1'b0; end
    temp_ok = 1'b0;
    for (int t = 8; t <= 10; t++) tick();
    temp_ok = 1'b1;
    wait_done(0, 30, c);
    check("cold_done_cyc", 32'(c + 10), 32'd13);

    // Auto-repeat eight jobs: counter wraps 7 -> 0.
    do_reset();
    start[0] = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      wait_done(0, 30, c);
      check($sformatf("rep_period_%0d", j), 32'(c), 32'd10);
      if (j == 7) check("rep_count7", 32'(count_o[2:0]), 32'd7);
      if (j == 8) begin
        check("rep_wrapcnt", 32'(count_o[2:0]), 32'd0);
        check("rep_wrap", 32'(wrap_o[0]), 32'd1);
      end
    end
    set_idle();

    // Randomized traffic against the model.
    for (int t = 0; t < 4000; t++) begin
      logic [MW-1:0] mv;
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        start[i]     = ($urandom_range(0, 2) == 0);
        stock_ok[i]  = ($urandom_range(0, 19) != 0);
        box_ok[i]    = ($urandom_range(0, 9) < 7);
        ack_fault[i] = ($urandom_range(0, 9) < 3);
        case ($urandom_range(0, 19))
          0, 1:    mv = MW'($urandom);
          2, 3, 4, 5, 6, 7: mv = 3'b001;
          8, 9, 10, 11, 12, 13: mv = 3'b010;
          default: mv = 3'b100;
        endcase
        mat[i*MW +: MW] = mv;
      end
      temp_ok = ($urandom_range(0, 4) != 0);
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
